key_led_stretch: RTL and testbench

Drives the three active-low key-indicator LEDs from the one-cycle key-press pulses produced by the switch debouncer. Each pulse becomes a visible flash of fixed length, followed by a fixed dark gap, so that rapid presses still appear as separate flashes. One further press per channel can be queued during a flash or gap. It sits between the debouncer's 3-bit pulse output and the board LED pins.

---
 rtl/key_led_pkg.sv | 18 +
 rtl/key_led_ch.sv | 129 ++++++++++++
 rtl/key_led_stretch.sv | 34 +++
 tb/tb_key_led_stretch.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/key_led_pkg.sv
// Shared definitions for the key-indicator LED stretcher: channel state
// encoding, channel count and default timing constants.
package key_led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned NUM_KEYS = 3;

  // 100 ms flash and 50 ms forced dark gap at 50 MHz
  localparam int unsigned DEF_HOLD_CYCLES = 5_000_000;
  localparam int unsigned DEF_GAP_CYCLES  = 2_500_000;
  localparam int unsigned DEF_CNT_W       = 23;

endpackage : key_led_pkg

// File: rtl/key_led_ch.sv
// One LED stretcher channel: IDLE/ON/GAP FSM, down-counter and a
// single-entry press queue.
// Optional feature macro: RETRIGGER_EN (a press during ON extends the flash).
module key_led_ch
  import key_led_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic key_pulse,
  output logic led_n,
  output logic busy,
  output logic drop
);

  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD  = CNT_W'(GAP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             led_n_q, led_n_d;
  logic             drop_q, drop_d;

  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // State, counter, queue slot and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      led_n_q   <= 1'b1;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      led_n_q   <= led_n_d;
      drop_q    <= drop_d;
    end
  end

  // Next-state, counter and press-queue logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    drop_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (key_pulse) begin
          state_d = ON;
          cnt_d   = HOLD_RELOAD;
        end
      end

      ON: begin
`ifdef RETRIGGER_EN
        if (key_pulse) begin
          cnt_d = HOLD_RELOAD;
        end else if (cnt_zero) begin
          state_d = GAP;
          cnt_d   = GAP_RELOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
`else
        if (key_pulse) begin
          if (pending_q) begin
            drop_d = 1'b1;
          end else begin
            pending_d = 1'b1;
          end
        end
        if (cnt_zero) begin
          state_d = GAP;
          cnt_d   = GAP_RELOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
`endif
      end

      GAP: begin
        if (cnt_zero) begin
          if (pending_q || key_pulse) begin
            state_d   = ON;
            cnt_d     = HOLD_RELOAD;
            // Queued press is consumed; a press arriving on this same edge
            // refills the slot instead of being dropped.
            pending_d = pending_q & key_pulse;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (key_pulse) begin
            if (pending_q) begin
              drop_d = 1'b1;
            end else begin
              pending_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        pending_d = 1'b0;
      end
    endcase

    // LED follows the upcoming state so it lights on the pulse's own edge
    led_n_d = (state_d != ON);
  end

  assign led_n = led_n_q;
  assign busy  = (state_q != IDLE);
  assign drop  = drop_q;

endmodule : key_led_ch

// File: rtl/key_led_stretch.sv
// Key-indicator LED stretcher: turns one-cycle debounced key pulses into
// fixed-length active-low LED flashes separated by a fixed dark gap.
// Optional feature macro: RETRIGGER_EN (a press during ON extends the flash).
module key_led_stretch
  import key_led_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] led_n,
  output logic [NUM_KEYS-1:0] busy,
  output logic [NUM_KEYS-1:0] drop
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_led_ch #(
      .HOLD_CYCLES(HOLD_CYCLES),
      .GAP_CYCLES (GAP_CYCLES),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .key_pulse(key_pulse[i]),
      .led_n    (led_n[i]),
      .busy     (busy[i]),
      .drop     (drop[i])
    );
  end

endmodule : key_led_stretch

// File: tb/tb_key_led_stretch.sv
// Directed bench for key_led_stretch with HOLD_CYCLES=4, GAP_CYCLES=2.
// Expected waveforms are per-edge bit masks (bit e = value just after edge e).
module tb_key_led_stretch;

  logic       clk;
  logic       rst;
  logic [2:0] key_pulse;
  logic [2:0] led_n;
  logic [2:0] busy;
  logic [2:0] drop;

  int unsigned n_checks;
  int unsigned n_fail;

  key_led_stretch #(
    .HOLD_CYCLES(4),
    .GAP_CYCLES (2),
    .CNT_W      (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_pulse(key_pulse),
    .led_n    (led_n),
    .busy     (busy),
    .drop     (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, act[2:0], exp[2:0]);
    end
  endtask

  // Hold reset for three edges, release just after an edge
  task automatic do_reset();
    rst       = 1'b1;
    key_pulse = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_led_n", 32'(led_n), 32'b111);
    check_eq("rst_busy",  32'(busy),  32'b000);
    check_eq("rst_drop",  32'(drop),  32'b000);
    rst = 1'b0;
  endtask

  // Drive pulses for ch0/ch2 per mask, check all channels after each edge.
  task automatic run_scn(input string name, input int unsigned n_edges,
                         input logic [31:0] p0, input logic [31:0] l0,
                         input logic [31:0] b0, input logic [31:0] d0,
                         input logic [31:0] p2, input logic [31:0] l2,
                         input logic [31:0] b2, input logic [31:0] d2);
    for (int unsigned e = 0; e < n_edges; e++) begin
      key_pulse = {p2[e], 1'b0, p0[e]};
      @(posedge clk);
      #1;
      key_pulse = '0;
      check_eq($sformatf("%s_led_n_e%0d", name, e), 32'(led_n),
               32'({~l2[e], 1'b1, ~l0[e]}));
      check_eq($sformatf("%s_busy_e%0d", name, e), 32'(busy),
               32'({b2[e], 1'b0, b0[e]}));
      check_eq($sformatf("%s_drop_e%0d", name, e), 32'(drop),
               32'({d2[e], 1'b0, d0[e]}));
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    key_pulse = '0;

    // Reset then idle for 20 edges
    do_reset();
    run_scn("idle", 20, '0, '0, '0, '0, '0, '0, '0, '0);

    // Single press on key 0 at edge 10
    do_reset();
    run_scn("single", 20, 32'h400, 32'h3C00, 32'hFC00, '0,
            '0, '0, '0, '0);

`ifdef RETRIGGER_EN
    // Press at 12 extends the flash: low 10..15, gap 16..17
    do_reset();
    run_scn("retrig", 24, 32'h1400, 32'hFC00, 32'h3FC00, '0,
            '0, '0, '0, '0);

    // Three presses all retrigger, nothing dropped
    do_reset();
    run_scn("ovf", 24, 32'h1C00, 32'hFC00, 32'h3FC00, '0,
            '0, '0, '0, '0);

    // ch0 retriggered while ch2 flashes alone from edge 11
    do_reset();
    run_scn("indep", 24, 32'h1400, 32'hFC00, 32'h3FC00, '0,
            32'h800, 32'h7800, 32'h1F800, '0);
`else
    // Press at 12 is queued: flashes 10..13 and 16..19
    do_reset();
    run_scn("queued", 26, 32'h1400, 32'hF3C00, 32'h3FFC00, '0,
            '0, '0, '0, '0);

    // Third press at 12 overflows the queue: drop one cycle after edge 12
    do_reset();
    run_scn("ovf", 26, 32'h1C00, 32'hF3C00, 32'h3FFC00, 32'h1000,
            '0, '0, '0, '0);

    // ch0 queued pair while ch2 flashes alone from edge 11
    do_reset();
    run_scn("indep", 26, 32'h1400, 32'hF3C00, 32'h3FFC00, '0,
            32'h800, 32'h7800, 32'h1F800, '0);
`endif

    // Reset mid-flash: presses at 10 and 11, reset just after edge 12
    do_reset();
    run_scn("pre_rst", 13, 32'hC00, 32'h1C00, 32'h1C00, '0,
            '0, '0, '0, '0);
    rst = 1'b1;
    #1;
    check_eq("midrst_led_n", 32'(led_n), 32'b111);
    check_eq("midrst_busy",  32'(busy),  32'b000);
    check_eq("midrst_drop",  32'(drop),  32'b000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_scn("post_rst", 20, '0, '0, '0, '0, '0, '0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule : tb_key_led_stretch
